// File: rtl/switch_port_ingress.sv
// Per-port ingress: validates, classifies and buffers single-beat packets,
// then presents the head packet to the crossbar as per-destination requests.
module switch_port_ingress #(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_source,
  input  logic [3:0]        in_target,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        out_req,
  input  logic [3:0]        out_gnt,
  output logic [3:0]        out_source,
  output logic [3:0]        out_target,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_type,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [3:0] OWN = 4'(1 << PORT_ID);
  localparam logic [3:0] BCAST = ~OWN;

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state;
  logic [3:0]        pending;
  logic [AW:0]       count;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [3:0]        src_mem  [DEPTH];
  logic [3:0]        tgt_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic       accept;
  logic       pkt_ok;
  logic       push;
  logic       pop;
  logic       empty;
  logic [3:0] next_pend;
  logic [3:0] head_tgt;

  function automatic logic [1:0] classify(input logic [3:0] t);
    logic [2:0] n;
    n = 3'(t[0]) + 3'(t[1]) + 3'(t[2]) + 3'(t[3]);
    if (n == 3'd1)      classify = 2'b00;
    else if (t == BCAST) classify = 2'b10;
    else                 classify = 2'b01;
  endfunction

  assign in_ready  = (count != FULL);
  assign empty     = (count == '0);
  assign accept    = in_valid && in_ready;
  assign pkt_ok    = (in_source == OWN) && (in_target != 4'b0)
                  && !in_target[PORT_ID];
  assign push      = accept && pkt_ok;
  assign next_pend = pending & ~out_gnt;
  // pop only frees the head once every pending destination has granted
  assign pop       = !empty && ((state == IDLE) || (next_pend == 4'b0));
  assign head_tgt  = tgt_mem[rd_ptr];
  assign out_req   = pending;

  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr]  <= in_source;
      tgt_mem[wr_ptr]  <= in_target;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      err_pulse <= accept && !pkt_ok;
      if (accept && !pkt_ok && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 4'b0;
      out_source <= 4'b0;
      out_target <= 4'b0;
      out_data   <= '0;
      out_type   <= 2'b00;
    end else if (pop) begin
      state      <= REQ;
      pending    <= head_tgt;
      out_source <= src_mem[rd_ptr];
      out_target <= head_tgt;
      out_data   <= data_mem[rd_ptr];
      out_type   <= classify(head_tgt);
    end else if (state == REQ) begin
      pending <= next_pend;
      if (next_pend == 4'b0) begin
        state      <= IDLE;
        out_source <= 4'b0;
        out_target <= 4'b0;
        out_data   <= '0;
        out_type   <= 2'b00;
      end
    end
  end

endmodule
